fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Write-side counterpart of the VGA scan counters: takes a valid/ready byte stream of decrypted pixels and writes it raster-order into the framebuffer RAM.
- The VGA read side scans that same RAM.
- Generates the linear write address plus x/y coordinates.
- Reports busy/done per frame; sits between the RSA decryption datapath and the framebuffer write port.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 320, lines per frame.
- DATA_W, 8, pixel width in bits.
- ADDR_W, $clog2(WIDTH*HEIGHT), write address width (17 at defaults).

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; sampled in IDLE or DONE only.
- in_valid  input  1  in_data valid.
- in_data  input  DATA_W  pixel byte.
- in_ready  output  1  block accepts in_data this cycle.
- we  output  1  framebuffer write enable, registered.
- waddr  output  ADDR_W  framebuffer write address, registered.
- wdata  output  DATA_W  framebuffer write data, registered.
- x  output  $clog2(WIDTH)  column of next pixel to accept.
- y  output  $clog2(HEIGHT)  line of next pixel to accept.
- busy  output  1  high in WRITE (and CLEAR, if compiled in).
- done  output  1  high in DONE.

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE; addr, x, y = 0.
  - we, waddr, wdata = 0; busy, done, in_ready = 0.
  - A partially written frame is abandoned; no further writes.
- States: IDLE, WRITE, DONE (+CLEAR with macro).
- IDLE: in_ready=0, we=0. start=1 -> WRITE; addr, x, y := 0.
- WRITE:
  - in_ready=1 (combinational from state only; not dependent on in_valid).
  - Accept = in_valid & in_ready.
  - On accept, next edge: we=1, waddr=addr, wdata=in_data (1-cycle latency from accept to write).
  - Then addr := addr+1; x := x+1.
  - If x==WIDTH-1: x := 0, y := y+1.
  - No accept: we=0, counters hold.
  - in_valid gaps of any length are allowed.
- Last pixel: accept while addr==WIDTH*HEIGHT-1 ->
  - Write issued as normal.
  - addr, x, y := 0 (wrap); state := DONE.
  - in_ready=0 from the following cycle; the pixel after the last is never accepted.
- DONE:
  - done=1, busy=0, we=0 (after the final write cycle).
  - Holds until start.
  - start=1 -> WRITE with done cleared the next cycle (back-to-back frames: one idle cycle between frames).
- start while in WRITE: ignored; no restart.
- in_valid in IDLE/DONE: ignored; in_ready=0, nothing consumed.
- Exactly WIDTH*HEIGHT writes per frame; waddr strictly increasing 0..WIDTH*HEIGHT-1; never exceeds the last address.
- Address arithmetic: unsigned, ADDR_W bits; the last-address compare uses the parameterised constant, never a power-of-two wrap.

Optional Feature:
- FB_WRITER_CLEAR_EN.
- Defined:
  - Adds input clear (1 bit) and parameter CLEAR_VALUE (default 0, DATA_W bits).
  - clear=1 in IDLE or DONE -> CLEAR state: in_ready=0, busy=1.
  - One write per cycle, wdata=CLEAR_VALUE, addresses 0..WIDTH*HEIGHT-1.
  - Then -> IDLE with done=0.
  - If start and clear are both high, clear wins.
  - Reset during CLEAR -> IDLE.
- Undefined: no clear port, no CLEAR_VALUE parameter, no CLEAR state; behaviour exactly as above.

Test Plan (bench uses WIDTH=4, HEIGHT=3, DATA_W=8, ADDR_W=4):
- Reset then start, in_valid held high, in_data=0x10..0x1B -> 12 writes:
  - waddr 0..11, wdata 0x10..0x1B, each one cycle after its accept.
  - done=1 after the 12th; in_ready=0 thereafter.
- Coordinates: accept 5 pixels -> x=1, y=1; accept the 8th -> x=0, y=2.
- Random in_valid gaps (~50% duty) over a full frame -> exactly 12 writes, no duplicate or skipped address, we only on accept.
- start pulsed mid-frame after 6 pixels -> ignored; frame completes at waddr 11 with exactly 12 writes.
- Reset asserted after 7 accepts -> outputs 0 same cycle (async), state IDLE. Then start -> first write at waddr=0.
- With FB_WRITER_CLEAR_EN, CLEAR_VALUE=0xFF, pulse clear in DONE:
  - 12 consecutive cycles with we=1, waddr 0..11, wdata 0xFF.
  - busy=1 throughout, in_ready=0, then IDLE.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
// ---------------
// Write-side counterpart of the VGA scan counters. Accepts a valid/ready byte
// stream of decrypted pixels and writes it in raster order into the
// framebuffer RAM that the VGA read side scans. Produces the linear write
// address plus the x/y coordinate of the next pixel, and reports busy/done
// once per frame.
//
// Optional feature: define FB_WRITER_CLEAR_EN to add a 'clear' input and the
// CLEAR_VALUE parameter. A clear fills the whole framebuffer with CLEAR_VALUE,
// one write per cycle, and then returns to IDLE.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     begin a frame (sampled in IDLE or DONE only)
//   clear     (FB_WRITER_CLEAR_EN only) fill the frame with CLEAR_VALUE
//   in_valid  in_data is valid
//   in_data   pixel byte
//   in_ready  block accepts in_data this cycle (high only in WRITE)
//   we        framebuffer write enable (registered)
//   waddr     framebuffer write address (registered)
//   wdata     framebuffer write data (registered)
//   x, y      column / line of the next pixel to accept
//   busy      high in WRITE (and CLEAR)
//   done      high in DONE

module fb_pixel_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 320,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
`ifdef FB_WRITER_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
`ifdef FB_WRITER_CLEAR_EN
  input  logic                      clear,
`endif
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic                      busy,
  output logic                      done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  // The last-address compare uses the real frame size, so a non power-of-two
  // frame ends exactly at WIDTH*HEIGHT-1 rather than at the counter wrap.
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH*HEIGHT - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);

`ifdef FB_WRITER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, DONE, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic accept;
  logic load_zero;
  logic advance;
  logic clear_write;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter control. 'advance' steps the address/coordinate
  // counters and 'load_zero' rewinds them when a new frame or clear begins.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    load_zero   = 1'b0;
    advance     = 1'b0;
    clear_write = 1'b0;
    case (state)
      IDLE, DONE: begin
`ifdef FB_WRITER_CLEAR_EN
        if (clear) begin
          state_next = CLEAR;
          load_zero  = 1'b1;
        end else
`endif
        if (start) begin
          state_next = WRITE;
          load_zero  = 1'b1;
        end
      end
      WRITE: begin
        accept = in_valid;
        if (in_valid) begin
          advance = 1'b1;
          if (addr == ADDR_LAST) begin
            state_next = DONE;
          end
        end
      end
`ifdef FB_WRITER_CLEAR_EN
      CLEAR: begin
        clear_write = 1'b1;
        advance     = 1'b1;
        if (addr == ADDR_LAST) begin
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address and coordinate counters. The last pixel wraps everything to zero
  // so x/y already point at the start of the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if (load_zero) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if (advance) begin
      if (addr == ADDR_LAST) begin
        addr <= '0;
        x    <= '0;
        y    <= '0;
      end else begin
        addr <= addr + ADDR_W'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  // Registered write port: one cycle from accept to the framebuffer write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= accept | clear_write;
      if (accept) begin
        waddr <= addr;
        wdata <= in_data;
      end
`ifdef FB_WRITER_CLEAR_EN
      else if (clear_write) begin
        waddr <= addr;
        wdata <= CLEAR_VALUE;
      end
`endif
    end
  end

  // in_ready depends on state only, never on in_valid.
  assign in_ready = (state == WRITE);
  assign done     = (state == DONE);
`ifdef FB_WRITER_CLEAR_EN
  assign busy     = (state == WRITE) || (state == CLEAR);
`else
  assign busy     = (state == WRITE);
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer on a 4x3 frame. Stimulus pushes the expected
// {waddr, wdata} of every accepted pixel into a queue; a monitor pops and
// compares whenever the DUT asserts we.

module tb_fb_pixel_writer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
`ifdef FB_WRITER_CLEAR_EN
  logic              clear;
`endif
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        x;
  logic [1:0]        y;
  logic              busy;
  logic              done;

  int checks = 0;
  int passed = 0;

  logic [11:0] exp_q[$];

  // Bench model of the writer
  int model_addr  = 0;
  bit model_write = 1'b0;
  bit model_done  = 1'b0;

  fb_pixel_writer #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
`ifdef FB_WRITER_CLEAR_EN
    ,
    .CLEAR_VALUE(8'hFF)
`endif
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
`ifdef FB_WRITER_CLEAR_EN
    .clear   (clear),
`endif
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write the DUT issues must match the next expected one.
  always @(negedge clk) begin
    logic [11:0] e;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL spurious_write: got we=1 waddr=%0d wdata=0x%0h, expected no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("waddr", 32'(waddr), 32'(e[11:8]));
        checkOutput("wdata", 32'(wdata), 32'(e[7:0]));
      end
    end
  end

  // Called at posedge+1: pulse start for one edge; the DUT is then in WRITE.
  task automatic startFrame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_write = 1'b1;
    model_done  = 1'b0;
    model_addr  = 0;
    checkOutput("busy_start", 32'(busy), 32'd1);
    checkOutput("in_ready_start", 32'(in_ready), 32'd1);
    checkOutput("x_start", 32'(x), 32'd0);
    checkOutput("y_start", 32'(y), 32'd0);
  endtask

  // Present one cycle of stream input and check the cycle that follows.
  task automatic applyStimulus(input logic [7:0] data, input logic valid);
    logic acc;
    in_valid = valid;
    in_data  = data;
    acc = valid & model_write;
    checkOutput("in_ready", 32'(in_ready), 32'(model_write));
    if (acc) begin
      exp_q.push_back({4'(model_addr), data});
      model_addr++;
      if (model_addr == NPIX) begin
        model_addr  = 0;
        model_write = 1'b0;
        model_done  = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("we_after_accept", 32'(we), 32'(acc));
    checkOutput("x", 32'(x), 32'(model_addr % WIDTH));
    checkOutput("y", 32'(y), 32'(model_addr / WIDTH));
    checkOutput("done", 32'(done), 32'(model_done));
    checkOutput("busy", 32'(busy), 32'(model_write));
  endtask

  task automatic endFrame();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("we_idle", 32'(we), 32'd0);
    checkOutput("done_hold", 32'(done), 32'(model_done));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
`ifdef FB_WRITER_CLEAR_EN
    clear    = 1'b0;
`endif
    in_valid = 1'b0;
    in_data  = '0;
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_waddr", 32'(waddr), 32'd0);
    checkOutput("rst_wdata", 32'(wdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // in_valid in IDLE is ignored
    applyStimulus(8'h55, 1'b1);

    // Frame 1: in_valid held high, data 0x10..0x1B
    $display("[TB] frame 1: continuous stream");
    startFrame();
    for (int i = 0; i < NPIX; i++) applyStimulus(8'(8'h10 + i), 1'b1);
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hAB, 1'b1);
    endFrame();

    // Frame 2: random gaps, started from DONE
    $display("[TB] frame 2: random in_valid gaps");
    startFrame();
    for (int n = 0; n < 400 && model_write; n++)
      applyStimulus(8'(8'h20 + model_addr), 1'($urandom_range(0, 1)));
    endFrame();

    // Frame 3: start pulsed mid-frame is ignored
    $display("[TB] frame 3: start mid-frame");
    startFrame();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h30 + i), 1'b1);
    start = 1'b1;
    applyStimulus(8'h00, 1'b0);
    start = 1'b0;
    for (int i = 6; i < NPIX; i++) applyStimulus(8'(8'h30 + i), 1'b1);
    endFrame();

    // Frame 4: reset after 7 accepts, then a fresh frame
    $display("[TB] frame 4: reset mid-frame");
    startFrame();
    for (int i = 0; i < 7; i++) applyStimulus(8'(8'h40 + i), 1'b1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_we", 32'(we), 32'd0);
    checkOutput("arst_waddr", 32'(waddr), 32'd0);
    checkOutput("arst_wdata", 32'(wdata), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("arst_x", 32'(x), 32'd0);
    checkOutput("arst_y", 32'(y), 32'd0);
    checkOutput("arst_queue", 32'(exp_q.size()), 32'd0);
    model_addr  = 0;
    model_write = 1'b0;
    model_done  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(8'h66, 1'b1);
    startFrame();
    for (int i = 0; i < NPIX; i++) applyStimulus(8'(8'h50 + i), 1'b1);
    endFrame();

`ifdef FB_WRITER_CLEAR_EN
    // Clear from DONE: 12 writes of 0xFF, then IDLE
    $display("[TB] clear from DONE");
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NPIX; i++) exp_q.push_back({4'(i), 8'hFF});
    for (int i = 0; i < NPIX; i++) begin
      checkOutput("clr_busy", 32'(busy), 32'd1);
      checkOutput("clr_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      checkOutput("clr_we", 32'(we), 32'd1);
    end
    checkOutput("clr_end_busy", 32'(busy), 32'd0);
    checkOutput("clr_end_done", 32'(done), 32'd0);
    model_done = 1'b0;
    endFrame();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
